// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package rv_fetch_pkg;

  localparam int unsigned ADDR_W_DEF   = 10;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc,instr} holding register that catches read data arriving while decode is stalled.
module fetch_skid_buf
  import rv_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  // Clear beats push: a flush must drop whatever was arriving that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch-side sequencer for a single-port synchronous instruction RAM shared with a program loader.
module imem_fetch_ctrl
  import rv_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = rv_fetch_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_gnt,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              stall,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_q;
  logic         inflight;

  logic         run;
  logic         flush;
  logic         consume;
  logic         out_free;
  logic         ret;
  logic         free_slot;
  logic         issue;
  logic         skid_push;
  logic         skid_pop;
  logic         skid_full;
  fetch_entry_t skid_dout;

  // Issue/return qualifiers; a flush drops the read returning in the same cycle.
  always_comb begin
    run       = (state == RUN);
    flush     = run & (ld_req | redirect);
    consume   = instr_valid & ~stall;
    out_free  = ~instr_valid | ~stall;
    ret       = run & inflight & ~flush;
    free_slot = ~skid_full & ~(instr_valid & stall & inflight);
    issue     = run & ~ld_req & ~redirect & fetch_en & free_slot;
    skid_push = ret & ~out_free;
    skid_pop  = ~flush & skid_full & out_free;
  end

  // RAM port mux: loader owns the port in LOAD, fetch reads in RUN.
  always_comb begin
    ld_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc[ADDR_W+1:2];
    mem_wdata = '0;
    if (state == LOAD) begin
      ld_gnt    = ld_req;
      mem_en    = ld_req;
      mem_we    = ld_req;
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end else if (issue) begin
      mem_en = 1'b1;
    end
  end

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (skid_push),
    .pop   (skid_pop),
    .clear (flush),
    .din   ('{pc: pc_q, instr: mem_rdata}),
    .dout  (skid_dout),
    .full  (skid_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pc_q        <= '0;
      inflight    <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_q <= pc;
        pc   <= pc + 32'd4;
      end
      case (state)
        IDLE: begin
          if (ld_req) state <= LOAD;
          else if (fetch_en) state <= RUN;
        end
        LOAD: begin
          if (!ld_req) begin
            state <= IDLE;
            pc    <= RESET_PC;
          end
        end
        RUN: begin
          if (flush) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            if (ld_req) state <= LOAD;
            else pc <= redirect_pc & ~32'd3;
          end else begin
            // Skid entry is older than anything in flight, so it drains first.
            if (skid_pop) begin
              instr_valid <= 1'b1;
              instr       <= skid_dout.instr;
              instr_pc    <= skid_dout.pc;
            end else if (ret && out_free) begin
              instr_valid <= 1'b1;
              instr       <= mem_rdata;
              instr_pc    <= pc_q;
            end else if (consume) begin
              instr_valid <= 1'b0;
              instr       <= NOP_INSTR;
            end
            if (!fetch_en && !inflight && !skid_full && (!instr_valid || consume))
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural 1-cycle-latency RAM.
module tb_imem_fetch_ctrl;

  localparam int unsigned ADDR_W = 10;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_en;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_gnt;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              stall;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int errors = 0;
  int checks = 0;

  imem_fetch_ctrl dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data valid only the cycle after a read, garbage otherwise.
  logic [31:0] ram [1024];
  logic [31:0] rd_q;
  logic        rd_v;
  always @(posedge clk) begin
    rd_v <= 1'b0;
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else begin
        rd_q <= ram[mem_addr];
        rd_v <= 1'b1;
      end
    end
  end
  assign mem_rdata = rd_v ? rd_q : 32'hDEAD_BEEF;

  function automatic logic [31:0] val(input int unsigned a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    int n;
    ld_req  = 1'b1;
    ld_addr = a;
    ld_data = d;
    #1;
    n = 0;
    while (!ld_gnt && n < 10) begin
      tick();
      n++;
    end
    check("ld_gnt", 32'(ld_gnt), 32'd1);
    check("ld_we", 32'(mem_we), 32'd1);
    check("ld_addr", 32'(mem_addr), 32'(a));
    tick();
  endtask

  initial begin
    int got_pc [3];
    int ngot;
    int n;

    rst = 1'b1; fetch_en = 1'b0; ld_req = 1'b0; ld_addr = '0; ld_data = '0;
    redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_gnt", 32'(ld_gnt), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    rst = 1'b0;

    // Preload program words, including the top word for the wrap test.
    for (int i = 0; i < 8; i++) load_word(ADDR_W'(i), val(i));
    load_word(ADDR_W'(1023), val(1023));
    ld_req = 1'b0; fetch_en = 1'b1;
    tick(); tick();
    #1;
    check("t1_c0_en", 32'(mem_en), 32'd1);
    check("t1_c0_addr", 32'(mem_addr), 32'd0);
    check("t1_c0_valid", 32'(instr_valid), 32'd0);
    tick(); #1;
    check("t1_c1_valid", 32'(instr_valid), 32'd0);
    check("t1_c1_addr", 32'(mem_addr), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check("t1_valid", 32'(instr_valid), 32'd1);
      check("t1_pc", instr_pc, 32'(4 * k));
      check("t1_instr", instr, val(k));
    end

    // Loader takeover while a read is in flight.
    tick();
    ld_req = 1'b1; ld_addr = ADDR_W'(10'h040); ld_data = 32'h5A5A_0100;
    #1;
    check("t4_gnt_wait", 32'(ld_gnt), 32'd0);
    check("t4_no_issue", 32'(mem_en), 32'd0);
    check("t4_pc16", instr_pc, 32'd16);
    tick(); #1;
    check("t4_gnt", 32'(ld_gnt), 32'd1);
    check("t4_we", 32'(mem_we), 32'd1);
    check("t4_addr", 32'(mem_addr), 32'h40);
    check("t4_flush", 32'(instr_valid), 32'd0);
    tick();
    ld_req = 1'b0;
    tick(); #1;
    check("t4_idle_valid", 32'(instr_valid), 32'd0);
    tick(); #1;
    check("t4_restart_addr", 32'(mem_addr), 32'd0);
    check("t4_restart_en", 32'(mem_en), 32'd1);
    tick(); tick(); #1;
    check("t4_first_pc", instr_pc, 32'd0);
    check("t4_first_valid", 32'(instr_valid), 32'd1);

    // Stall three cycles on pc=4.
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t2_hold_pc", instr_pc, 32'd4);
      check("t2_hold_valid", 32'(instr_valid), 32'd1);
      check("t2_no_mem_en", 32'(mem_en), 32'd0);
      tick();
    end
    stall = 1'b0;
    ngot = 0;
    n = 0;
    while (ngot < 3 && n < 8) begin
      #1;
      if (instr_valid && !stall) begin
        got_pc[ngot] = int'(instr_pc);
        ngot++;
      end
      if (ngot < 3) tick();
      n++;
    end
    check("t2_count", 32'(ngot), 32'd3);
    check("t2_seq0", 32'(got_pc[0]), 32'd4);
    check("t2_seq1", 32'(got_pc[1]), 32'd8);
    check("t2_seq2", 32'(got_pc[2]), 32'd12);

    // Redirect together with stall; low PC bits dropped.
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103; stall = 1'b1;
    #1;
    check("t3_no_issue", 32'(mem_en), 32'd0);
    tick();
    redirect = 1'b0; stall = 1'b0;
    #1;
    check("t3_flushed", 32'(instr_valid), 32'd0);
    check("t3_en", 32'(mem_en), 32'd1);
    check("t3_addr", 32'(mem_addr), 32'h40);
    tick(); #1;
    check("t3_bubble", 32'(instr_valid), 32'd0);
    tick(); #1;
    check("t3_valid", 32'(instr_valid), 32'd1);
    check("t3_pc", instr_pc, 32'h100);
    check("t3_instr", instr, 32'h5A5A_0100);

    // Address wrap at the top of the RAM.
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0FFC;
    #1;
    tick();
    redirect = 1'b0;
    #1;
    check("t5_addr_top", 32'(mem_addr), 32'h3FF);
    check("t5_en", 32'(mem_en), 32'd1);
    tick(); #1;
    check("t5_addr_wrap", 32'(mem_addr), 32'h000);
    tick(); #1;
    check("t5_pc_top", instr_pc, 32'h0000_0FFC);
    check("t5_instr_top", instr, val(1023));
    tick(); #1;
    check("t5_pc_next", instr_pc, 32'h0000_1000);
    check("t5_instr_next", instr, val(0));

    // Asynchronous reset mid-burst.
    #1;
    rst = 1'b1;
    #1;
    check("t6_valid", 32'(instr_valid), 32'd0);
    check("t6_instr", instr, NOP);
    check("t6_pc", instr_pc, 32'd0);
    check("t6_mem_en", 32'(mem_en), 32'd0);
    tick();
    rst = 1'b0;
    tick(); #1;
    check("t6_restart_en", 32'(mem_en), 32'd1);
    check("t6_restart_addr", 32'(mem_addr), 32'd0);
    tick(); tick(); #1;
    check("t6_restart_pc", instr_pc, 32'd0);
    check("t6_restart_instr", instr, val(0));

    // fetch_en drop: drain, go idle, then resume from the retained PC.
    fetch_en = 1'b0;
    n = 0;
    #1;
    while ((instr_valid || mem_en) && n < 8) begin
      tick();
      n++;
    end
    check("drain_valid", 32'(instr_valid), 32'd0);
    tick(); #1;
    check("drain_idle_en", 32'(mem_en), 32'd0);
    fetch_en = 1'b1;
    tick(); #1;
    check("resume_en", 32'(mem_en), 32'd1);
    check("resume_addr", 32'(mem_addr), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
